pipeline_ctrl: RTL and testbench

- Parametrised stall/flush controller for the in-order core pipeline. Generalises the fixed fetch/decode/dispatch stall-flush equations to NUM_STAGES stages, with per-stage stall and redirect requests.
- Adds behaviour the current core lacks: a post-reset drain sequence, a stall-timeout hang detector, and saturating performance counters.
- Sits in the core top level, between the stage request sources (dispatcher conflict, divider busy, ALU branch) and the pipeline register stall/flush inputs.

---
 rtl/pipeline_ctrl_pkg.sv | 19 +
 rtl/pipeline_ctrl_sat_counter.sv | 33 +++
 rtl/pipeline_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
// Shared definitions for the pipeline stall/flush controller:
//   pipe_ctrl_state_t : controller FSM states (RESET, DRAIN, RUN)
//   STG_*             : pipeline register indices, 0 = fetch output register
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    DRAIN = 2'd1,
    RUN   = 2'd2
  } pipe_ctrl_state_t;

  localparam int STG_FETCH    = 0;
  localparam int STG_DECODE   = 1;
  localparam int STG_DISPATCH = 2;
  localparam int STG_EXE      = 3;
  localparam int STG_WB       = 4;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// sat_counter
// Saturating up-counter with a synchronous clear.
//   clk   : clock
//   rst   : asynchronous active-high reset, count -> 0
//   inc   : add one this cycle (ignored once count == MAX_VAL)
//   clr   : zero the count on the next edge, wins over inc
//   count : current value
module sat_counter #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != MAX_VAL)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Stall/flush controller for an in-order pipeline of NUM_STAGES registers.
// After reset it flushes every register for DRAIN_CYCLES cycles, then in RUN
// turns per-stage stall/redirect requests into per-register stall/flush.
// Also keeps saturating performance counters and a sticky hang detector.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   stall_req       : bit i = stage i cannot accept new work
//   redirect_req    : bit k = stage k resolved a taken branch
//   clr_cnt         : synchronous clear of counters and hang
//   stall / flush   : per-register hold / bubble-load (flush dominates)
//   redirect_ack    : redirect honoured this cycle
//   ready           : controller is in RUN
//   hang            : sticky stall-timeout flag (registered)
//   stall_cycles    : RUN cycles with any stall asserted (registered)
//   redirect_count  : honoured redirects (registered)
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int NUM_STAGES    = 5,
  parameter int DRAIN_CYCLES  = 2,
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic [NUM_STAGES-1:0] redirect_req,
  input  logic                  clr_cnt,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  redirect_ack,
  output logic                  ready,
  output logic                  hang,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      redirect_count
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam int RUN_W = $clog2(STALL_TIMEOUT + 1);

  // Index of the highest set bit (0 when none set; callers check |v).
  function automatic logic [IDX_W-1:0] highest_set(input logic [NUM_STAGES-1:0] v);
    highest_set = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (v[i]) highest_set = IDX_W'(i);
    end
  endfunction

  // Ones in every bit position strictly below idx.
  function automatic logic [NUM_STAGES-1:0] below_mask(input logic [IDX_W-1:0] idx);
    below_mask = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      below_mask[i] = (i < int'(idx));
    end
  endfunction

  pipe_ctrl_state_t r_state, w_state_next;
  logic [DRN_W-1:0] r_drain_cnt, w_drain_next;
  logic [IDX_W-1:0] w_stall_idx, w_redir_idx;
  logic             w_redir_blocked, w_redir_take, w_any_stall;
  logic [RUN_W-1:0] w_run_cnt;
  logic             r_hang;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RESET;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_drain_cnt <= w_drain_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_drain_next = r_drain_cnt;
    case (r_state)
      RESET: begin
        w_state_next = DRAIN;
        w_drain_next = DRN_W'(DRAIN_CYCLES - 1);
      end
      DRAIN: begin
        if (r_drain_cnt == '0) w_state_next = RUN;
        else                   w_drain_next = r_drain_cnt - 1'b1;
      end
      RUN:     w_state_next = RUN;
      default: w_state_next = RESET;
    endcase
  end

  // ---------------- stall / flush / redirect ----------------
  assign w_stall_idx = highest_set(stall_req);
  assign w_redir_idx = highest_set(redirect_req);
  // A stall at or beyond the redirecting stage means the branch itself is
  // not moving yet, so the redirect must wait.
  assign w_redir_blocked = |(stall_req & ~below_mask(w_redir_idx));
  assign w_redir_take    = (|redirect_req) && !w_redir_blocked;

  always_comb begin
    stall        = '0;
    flush        = '0;
    redirect_ack = 1'b0;
    ready        = 1'b0;
    if (r_state != RUN) begin
      flush = '1;
    end else begin
      ready = 1'b1;
      if (w_redir_take) begin
        // Everything younger than the branch is squashed; their stalls are moot.
        flush        = below_mask(w_redir_idx);
        redirect_ack = 1'b1;
      end else if (|stall_req) begin
        stall              = below_mask(w_stall_idx);
        flush[w_stall_idx] = 1'b1;
      end
    end
  end

  // ---------------- counters and hang detector ----------------
  assign w_any_stall = |stall;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_any_stall),
    .clr   (clr_cnt),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_redir_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (redirect_ack),
    .clr   (clr_cnt),
    .count (redirect_count)
  );

  // Length of the current unbroken stall run, capped at STALL_TIMEOUT.
  sat_counter #(.WIDTH(RUN_W), .MAX_VAL(RUN_W'(STALL_TIMEOUT))) u_run_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_any_stall),
    .clr   (clr_cnt | ~w_any_stall),
    .count (w_run_cnt)
  );

  // Set on the same edge at which the run counter reaches STALL_TIMEOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hang <= 1'b0;
    end else if (clr_cnt) begin
      r_hang <= 1'b0;
    end else if (w_any_stall && (w_run_cnt >= RUN_W'(STALL_TIMEOUT - 1))) begin
      r_hang <= 1'b1;
    end
  end

  assign hang = r_hang;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: CNT_W=32, DUT 1: CNT_W=3 for the saturation check
  logic       rst0 = 1'b1, rst1 = 1'b1;
  logic [4:0] sreq0 = '0, sreq1 = '0, rreq0 = '0, rreq1 = '0;
  logic       clr0 = 1'b0, clr1 = 1'b0;
  logic [4:0] stall0, flush0, stall1, flush1;
  logic       ack0, ready0, hang0, ack1, ready1, hang1;
  logic [31:0] sc0, rc0;
  logic [2:0]  sc1, rc1;

  pipeline_ctrl #(.NUM_STAGES(5), .DRAIN_CYCLES(2), .STALL_TIMEOUT(4), .CNT_W(32)) u_dut0 (
    .clk(clk), .rst(rst0), .stall_req(sreq0), .redirect_req(rreq0), .clr_cnt(clr0),
    .stall(stall0), .flush(flush0), .redirect_ack(ack0), .ready(ready0), .hang(hang0),
    .stall_cycles(sc0), .redirect_count(rc0));

  pipeline_ctrl #(.NUM_STAGES(5), .DRAIN_CYCLES(2), .STALL_TIMEOUT(4), .CNT_W(3)) u_dut1 (
    .clk(clk), .rst(rst1), .stall_req(sreq1), .redirect_req(rreq1), .clr_cnt(clr1),
    .stall(stall1), .flush(flush1), .redirect_ack(ack1), .ready(ready1), .hang(hang1),
    .stall_cycles(sc1), .redirect_count(rc1));

  typedef struct {
    string       name;
    int          dut;
    logic [4:0]  stall;
    logic [4:0]  flush;
    logic        ack;
    logic        ready;
    logic        hang;
    logic [31:0] sc;
    logic [31:0] rc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor: every negedge with a pending expectation, compare one transaction.
  exp_t        m_e;
  logic [4:0]  m_stall, m_flush;
  logic        m_ack, m_ready, m_hang;
  logic [31:0] m_sc, m_rc;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      if (m_e.dut == 0) begin
        m_stall = stall0; m_flush = flush0; m_ack = ack0; m_ready = ready0;
        m_hang = hang0; m_sc = sc0; m_rc = rc0;
      end else begin
        m_stall = stall1; m_flush = flush1; m_ack = ack1; m_ready = ready1;
        m_hang = hang1; m_sc = {29'd0, sc1}; m_rc = {29'd0, rc1};
      end
      n_cmp++;
      if (m_stall !== m_e.stall || m_flush !== m_e.flush || m_ack !== m_e.ack ||
          m_ready !== m_e.ready || m_hang !== m_e.hang || m_sc !== m_e.sc || m_rc !== m_e.rc) begin
        n_bad++;
        $display("FAIL %s: got stall=%b flush=%b ack=%b ready=%b hang=%b sc=%0d rc=%0d; want stall=%b flush=%b ack=%b ready=%b hang=%b sc=%0d rc=%0d",
                 m_e.name, m_stall, m_flush, m_ack, m_ready, m_hang, m_sc, m_rc,
                 m_e.stall, m_e.flush, m_e.ack, m_e.ready, m_e.hang, m_e.sc, m_e.rc);
      end else begin
        $display("ok   %s: stall=%b flush=%b ack=%b ready=%b hang=%b sc=%0d rc=%0d",
                 m_e.name, m_stall, m_flush, m_ack, m_ready, m_hang, m_sc, m_rc);
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge and queue the
  // outputs expected before the next rising edge.
  task automatic step(input string name, input int dut, input logic r,
                      input logic [4:0] sq, input logic [4:0] rq, input logic clr,
                      input logic [4:0] es, input logic [4:0] ef, input logic ea,
                      input logic erdy, input logic eh, input int esc, input int erc);
    exp_t e;
    @(posedge clk);
    #1;
    if (dut == 0) begin
      rst0 = r; sreq0 = sq; rreq0 = rq; clr0 = clr;
    end else begin
      rst1 = r; sreq1 = sq; rreq1 = rq; clr1 = clr;
    end
    e.name = name; e.dut = dut; e.stall = es; e.flush = ef; e.ack = ea;
    e.ready = erdy; e.hang = eh; e.sc = 32'(esc); e.rc = 32'(erc);
    exp_q.push_back(e);
  endtask

  initial begin
    //   name            dut rst sreq      rreq      clr  stall     flush     ack rdy hang sc rc
    step("reset",         0, 1, 5'b00000, 5'b00000, 0, 5'b00000, 5'b11111, 0, 0, 0, 0, 0);
    step("release",       0, 0, 5'b00000, 5'b00000, 0, 5'b00000, 5'b11111, 0, 0, 0, 0, 0);
    step("drain1",        0, 0, 5'b00000, 5'b00000, 0, 5'b00000, 5'b11111, 0, 0, 0, 0, 0);
    step("drain2",        0, 0, 5'b00000, 5'b00000, 0, 5'b00000, 5'b11111, 0, 0, 0, 0, 0);
    step("run_idle",      0, 0, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 1, 0, 0, 0);
    step("stall_s2",      0, 0, 5'b00100, 5'b00000, 0, 5'b00011, 5'b00100, 0, 1, 0, 0, 0);
    step("stall_s3s1",    0, 0, 5'b01010, 5'b00000, 0, 5'b00111, 5'b01000, 0, 1, 0, 1, 0);
    step("redir_k3",      0, 0, 5'b00010, 5'b01000, 0, 5'b00000, 5'b00111, 1, 1, 0, 2, 0);
    step("redir_blocked", 0, 0, 5'b01000, 5'b00100, 0, 5'b00111, 5'b01000, 0, 1, 0, 2, 1);
    step("redir_held",    0, 0, 5'b00000, 5'b00100, 0, 5'b00000, 5'b00011, 1, 1, 0, 3, 1);
    step("clr_pulse",     0, 0, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 1, 0, 3, 2);
    for (int i = 0; i < 4; i++)
      step("hang_stall",  0, 0, 5'b00010, 5'b00000, 0, 5'b00001, 5'b00010, 0, 1, 0, i, 0);
    step("hang_set",      0, 0, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 1, 1, 4, 0);
    step("hang_sticky",   0, 0, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 1, 1, 4, 0);
    step("after_clr",     0, 0, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 1, 0, 0, 0);
    step("clr_vs_inc",    0, 0, 5'b00010, 5'b00000, 1, 5'b00001, 5'b00010, 0, 1, 0, 0, 0);
    step("clr_won",       0, 0, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 1, 0, 0, 0);
    step("redir_multi",   0, 0, 5'b00000, 5'b01001, 0, 5'b00000, 5'b00111, 1, 1, 0, 0, 0);
    step("redir_k4_blk",  0, 0, 5'b10000, 5'b10000, 0, 5'b01111, 5'b10000, 0, 1, 0, 0, 1);
    // Reset asserted between edges: outputs must react before any clock edge.
    step("rst_async",     0, 1, 5'b00000, 5'b00000, 0, 5'b00000, 5'b11111, 0, 0, 0, 0, 0);

    // Narrow-counter instance: saturation at 7 with no wrap.
    step("d1_release",    1, 0, 5'b00000, 5'b00000, 0, 5'b00000, 5'b11111, 0, 0, 0, 0, 0);
    step("d1_drain1",     1, 0, 5'b00000, 5'b00000, 0, 5'b00000, 5'b11111, 0, 0, 0, 0, 0);
    step("d1_drain2",     1, 0, 5'b00000, 5'b00000, 0, 5'b00000, 5'b11111, 0, 0, 0, 0, 0);
    step("d1_idle",       1, 0, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 10; i++)
      step("d1_sat",      1, 0, 5'b00100, 5'b00000, 0, 5'b00011, 5'b00100, 0, 1,
           (i >= 5) ? 1'b1 : 1'b0, (i - 1 > 7) ? 7 : i - 1, 0);
    step("d1_after",      1, 0, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 1, 1, 7, 0);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_queue: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
